// File: rtl/mux2_arbiter_pkg.sv
// Shared definitions for the two-requester arbiter.
//   sel_e        : winner / mux select encoding (SEL_0 routes data0, SEL_1 routes data1)
//   buf_state_e  : output buffer occupancy
//   STARVE_MAX_DEFAULT : default number of back-to-back req0 wins tolerated in fixed-priority mode
package mux2_arbiter_pkg;

  typedef enum logic {
    SEL_0 = 1'b0,
    SEL_1 = 1'b1
  } sel_e;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } buf_state_e;

  localparam int unsigned STARVE_MAX_DEFAULT = 3;

  function automatic sel_e other_sel(input sel_e s);
    return (s == SEL_0) ? SEL_1 : SEL_0;
  endfunction

endpackage

// File: rtl/mux2_arbiter_mux.sv
// Plain 2:1 data multiplexer.
//   in0_i / in1_i : candidate words
//   sel_i         : 0 selects in0_i, 1 selects in1_i
//   out_o         : selected word
module mux2_arbiter_mux #(
  parameter int unsigned Width = 8
) (
  input  logic [Width-1:0] in0_i,
  input  logic [Width-1:0] in1_i,
  input  logic             sel_i,
  output logic [Width-1:0] out_o
);

  always_comb begin
    out_o = sel_i ? in1_i : in0_i;
  end

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester arbiter feeding a one-entry output buffer.
//   clk, rst_n       : clock, asynchronous active-low reset
//   prio_mode        : 0 = round-robin, 1 = fixed priority to req0 with starvation guard
//   req0/req1        : requests, held until granted
//   data0/data1      : request payloads
//   gnt0/gnt1        : combinational grants, high in the capture cycle
//   sel              : mux control (winner on capture, otherwise last value)
//   out_valid        : output buffer holds a word
//   out_ready        : downstream accepts the held word
//   out_data         : registered payload
//   xfer_count       : captured words, modulo 256
module mux2_arbiter
  import mux2_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prio_mode,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        xfer_count
);

  localparam int unsigned SCW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SCW-1:0] StarveLimit = SCW'(STARVE_MAX);

  buf_state_e        state_q, state_d;
  sel_e              last_q, last_d;
  sel_e              sel_q, sel_d;
  sel_e              winner;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] mux_out;
  logic [7:0]        cnt_q, cnt_d;
  logic [SCW-1:0]    starve_q, starve_d;
  logic              load_ok;
  logic              capture;

  // Arbitration
  always_comb begin
    winner = SEL_0;
    if (req0 && req1) begin
      if (prio_mode) begin
        winner = (starve_q == StarveLimit) ? SEL_1 : SEL_0;
      end else begin
        winner = other_sel(last_q);
      end
    end else if (req1) begin
      winner = SEL_1;
    end
  end

  // Grants are suppressed while reset is held so nothing is handshaken mid-reset.
  always_comb begin
    load_ok = (state_q == StEmpty) || out_ready;
    capture = rst_n && load_ok && (req0 || req1);
    gnt0    = capture && (winner == SEL_0);
    gnt1    = capture && (winner == SEL_1);
    sel_d   = capture ? winner : sel_q;
    sel     = sel_d;
  end

  mux2_arbiter_mux #(
    .Width(DATA_W)
  ) u_mux (
    .in0_i(data0),
    .in1_i(data1),
    .sel_i(sel),
    .out_o(mux_out)
  );

  // Buffer FSM and bookkeeping next-state
  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;

    if (capture) begin
      state_d    = StFull;
      out_data_d = mux_out;
      last_d     = winner;
      cnt_d      = cnt_q + 8'd1;
    end else if ((state_q == StFull) && out_ready) begin
      state_d = StEmpty;
    end

    // Counts req0 wins that happened while req1 was waiting.
    if (!req1) begin
      starve_d = '0;
    end else if (capture) begin
      if (winner == SEL_1) begin
        starve_d = '0;
      end else if (starve_q != StarveLimit) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      out_data_q <= '0;
      sel_q      <= SEL_0;
      last_q     <= SEL_1;  // req0 wins the first tie
      cnt_q      <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
    end
  end

  assign out_valid  = (state_q == StFull);
  assign out_data   = out_data_q;
  assign xfer_count = cnt_q;

endmodule
